// File: rtl/dsdmnist_pkg.sv
// Shared types for the MNIST image receive path: pixel type, frame geometry, receive FSM states.
package dsdmnist_pkg;
  typedef logic signed [7:0] pix_t;
  localparam int IMG_W     = 28;
  localparam int IMG_WORDS = 196;
  localparam int NPIX      = 4;
  typedef enum logic [1:0] {IDLE, RECV, COMMIT, DROP} rx_state_t;
endpackage

// File: rtl/dsdmnist_pingpong_ram.sv
// Two-bank word store: one write port, one registered read port; bank select is the address MSB.
module dsdmnist_pingpong_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW:0]   waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW:0]   raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**(AW+1)];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; array contents are don't-care until a frame commits.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dsdmnist_imgrecv.sv
// Frame receiver: captures WORDS 4-pixel words into a free ping-pong bank and exposes a read port.
module dsdmnist_imgrecv
  import dsdmnist_pkg::*;
#(
  parameter int WORDS = IMG_WORDS,
  parameter int AW    = 8
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  input  pix_t          i_DIN [0:3],
  input  logic          i_SHIFT,
  output logic          o_RXDONE,
  output logic [1:0]    o_BANK_VALID,
  output logic          o_BUSY,
  input  logic          i_RD_EN,
  input  logic          i_RD_BANK,
  input  logic [AW-1:0] i_RD_ADDR,
  output pix_t          o_RD_DOUT [0:3],
  output logic          o_RD_VALID,
  input  logic          i_RELEASE,
  output logic          o_OVERRUN,
  output logic          o_SHORT
);
  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  rx_state_t     state_q, state_d;
  logic [AW-1:0] cntr_q, cntr_d;
  logic          wr_bank_q, wr_bank_d;
  logic [1:0]    valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          short_q, short_d;
  logic          rdv_q;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata, rdata;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= IDLE;
      cntr_q    <= '0;
      wr_bank_q <= 1'b0;
      valid_q   <= '0;
      ovr_q     <= 1'b0;
      short_q   <= 1'b0;
      rdv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cntr_q    <= cntr_d;
      wr_bank_q <= wr_bank_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      short_q   <= short_d;
      rdv_q     <= i_RD_EN;
    end
  end

  always_comb begin
    state_d   = state_q;
    cntr_d    = cntr_q;
    wr_bank_d = wr_bank_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    short_d   = short_q;
    we        = 1'b0;
    waddr     = cntr_q;
    // Release is applied first so a commit to the write bank in the same cycle still sets it.
    if (i_RELEASE) valid_d[i_RD_BANK] = 1'b0;
    case (state_q)
      IDLE: if (i_SHIFT) begin
        if (!valid_q[wr_bank_q]) begin
          we      = 1'b1;
          waddr   = '0;
          cntr_d  = AW'(1);
          state_d = RECV;
        end else begin
          ovr_d   = 1'b1;
          state_d = DROP;
        end
      end
      RECV: if (i_SHIFT) begin
        we     = 1'b1;
        cntr_d = cntr_q + 1'b1;
        if (cntr_q == LAST) state_d = COMMIT;
      end else begin
        short_d = 1'b1;
        cntr_d  = '0;
        state_d = IDLE;
      end
      COMMIT: begin
        valid_d[wr_bank_q] = 1'b1;
        wr_bank_d          = ~wr_bank_q;
        cntr_d             = '0;
        if (i_SHIFT) begin
          ovr_d   = 1'b1;
          state_d = DROP;
        end else begin
          state_d = IDLE;
        end
      end
      DROP: if (!i_SHIFT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < NPIX; g++) begin : g_pix
    assign wdata[8*g +: 8] = i_DIN[g];
    assign o_RD_DOUT[g]    = rdata[8*g +: 8];
  end

  dsdmnist_pingpong_ram #(.AW(AW), .DW(32)) u_ram (
    .clk_i   (i_CLK),
    .rst_i   (i_RST),
    .we_i    (we),
    .waddr_i ({wr_bank_q, waddr}),
    .wdata_i (wdata),
    .re_i    (i_RD_EN),
    .raddr_i ({i_RD_BANK, i_RD_ADDR}),
    .rdata_o (rdata)
  );

  assign o_RXDONE     = (state_q == COMMIT);
  assign o_BUSY       = (state_q == RECV);
  assign o_BANK_VALID = valid_q;
  assign o_RD_VALID   = rdv_q;
  assign o_OVERRUN    = ovr_q;
  assign o_SHORT      = short_q;
endmodule

// File: tb/tb_dsdmnist_imgrecv.sv
// Bench for dsdmnist_imgrecv: directed frame table, corner sequences, random ops vs frame-level model.
module tb_dsdmnist_imgrecv;
  import dsdmnist_pkg::*;
  localparam int WORDS = 196;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst, shift, rxdone, busy, rd_en, rd_bank, rd_valid, rel_p, overrun, short_f;
  logic [1:0] bvalid;
  logic [AW-1:0] rd_addr;
  pix_t din [0:3];
  pix_t dout [0:3];

  always #5 clk = ~clk;

  dsdmnist_imgrecv #(.WORDS(WORDS), .AW(AW)) dut (
    .i_CLK(clk), .i_RST(rst), .i_DIN(din), .i_SHIFT(shift), .o_RXDONE(rxdone),
    .o_BANK_VALID(bvalid), .o_BUSY(busy), .i_RD_EN(rd_en), .i_RD_BANK(rd_bank),
    .i_RD_ADDR(rd_addr), .o_RD_DOUT(dout), .o_RD_VALID(rd_valid), .i_RELEASE(rel_p),
    .o_OVERRUN(overrun), .o_SHORT(short_f)
  );

  int total = 0, bad = 0, rxcnt = 0;
  always @(negedge clk) if (rxdone) rxcnt++;

  // Frame-level reference: bank contents, bank validity, next target bank, sticky flags.
  logic [31:0] mbank [2][WORDS];
  logic [1:0]  mval;
  logic        mwr, mov, msh;
  logic [31:0] fr [WORDS+8];

  typedef struct {
    int         rel;   // bank to release before the frame, -1 for none
    int         n;     // words driven
    logic [1:0] ev;
    logic       eov, esh;
    int         erx;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] dout_w();
    return {dout[3], dout[2], dout[1], dout[0]};
  endfunction

  task automatic model_clear();
    mval = 2'b00; mwr = 1'b0; mov = 1'b0; msh = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; shift = 1'b0; rd_en = 1'b0; rel_p = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic send_frame(input int n, input int seed, input bit rnd);
    int rx0, erx;
    logic fre;
    fre = !mval[mwr];
    rx0 = rxcnt;
    erx = 0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] w;
      for (int j = 0; j < 4; j++)
        w[8*j +: 8] = rnd ? 8'($urandom) : 8'((4*k + j + seed) % 32);
      if (k < WORDS + 8) fr[k] = w;
      for (int j = 0; j < 4; j++) din[j] = pix_t'(w[8*j +: 8]);
      shift = 1'b1;
      tick();
      if (n >= 4 && k == n/2 && k < WORDS-1) chk("busy_mid", busy, fre);
      if (k == WORDS-1) chk("rxdone_timing", rxdone, fre);
    end
    shift = 1'b0;
    tick(); tick(); tick();
    if (n > 0) begin
      if (!fre) mov = 1'b1;
      else if (n < WORDS) msh = 1'b1;
      else begin
        for (int a = 0; a < WORDS; a++) mbank[mwr][a] = fr[a];
        mval[mwr] = 1'b1;
        mwr = ~mwr;
        erx = 1;
        if (n > WORDS) mov = 1'b1;
      end
    end
    chk("rxdone_count", rxcnt - rx0, erx);
  endtask

  task automatic rel(input logic b);
    rel_p = 1'b1; rd_bank = b;
    tick();
    rel_p = 1'b0;
    mval[b] = 1'b0;
  endtask

  task automatic rd(input logic b, input int a, output logic [31:0] w);
    rd_en = 1'b1; rd_bank = b; rd_addr = AW'(a);
    tick();
    chk("rd_valid", rd_valid, 1'b1);
    w = dout_w();
    rd_en = 1'b0;
  endtask

  task automatic check_state();
    chk("bank_valid", bvalid, mval);
    chk("overrun", overrun, mov);
    chk("short", short_f, msh);
    chk("busy_idle", busy, 1'b0);
  endtask

  task automatic check_data();
    logic [31:0] w;
    int addrs [3];
    for (int b = 0; b < 2; b++) begin
      if (mval[b]) begin
        addrs[0] = 0; addrs[1] = WORDS-1; addrs[2] = $urandom_range(0, WORDS-1);
        for (int i = 0; i < 3; i++) begin
          rd(b[0], addrs[i], w);
          chk("rd_data", w, mbank[b][addrs[i]]);
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w, w2;
    int rx0;
    for (int j = 0; j < 4; j++) din[j] = '0;
    rd_bank = 1'b0; rd_addr = '0;
    do_reset();

    chk("rst_rxdone", rxdone, 1'b0);
    chk("rst_banks", bvalid, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdvalid", rd_valid, 1'b0);
    chk("rst_dout", dout_w(), 32'h0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_short", short_f, 1'b0);

    tbl[0] = '{-1, 196, 2'b01, 1'b0, 1'b0, 1};
    tbl[1] = '{-1, 100, 2'b01, 1'b0, 1'b1, 0};
    tbl[2] = '{-1, 196, 2'b11, 1'b0, 1'b1, 1};
    tbl[3] = '{-1, 196, 2'b11, 1'b1, 1'b1, 0};
    tbl[4] = '{ 0, 196, 2'b11, 1'b1, 1'b1, 1};
    tbl[5] = '{ 1, 197, 2'b11, 1'b1, 1'b1, 1};
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rel >= 0) rel(tbl[i].rel[0]);
      rx0 = rxcnt;
      send_frame(tbl[i].n, 5*i, 1'b0);
      chk("tbl_banks", bvalid, tbl[i].ev);
      chk("tbl_overrun", overrun, tbl[i].eov);
      chk("tbl_short", short_f, tbl[i].esh);
      chk("tbl_rxdone", rxcnt - rx0, tbl[i].erx);
      check_state();
      check_data();
      if (i == 0) begin
        // word 195 of a seed-0 frame is pixels 780..783 mod 32 = 12,13,14,15
        rd(1'b0, 195, w);
        chk("frame0_word195", w, 32'h0f0e0d0c);
        rd_en = 1'b0; rd_addr = 8'd0;
        tick();
        chk("rd_valid_drop", rd_valid, 1'b0);
        chk("rd_hold", dout_w(), w);
        rd(1'b0, 0, w2);
        chk("frame0_word0", w2, 32'h03020100);
      end
    end

    // 197 words after reset: commit, overrun, word 0 untouched by the extra word
    do_reset();
    send_frame(197, 3, 1'b0);
    chk("x197_banks", bvalid, 2'b01);
    chk("x197_overrun", overrun, 1'b1);
    chk("x197_short", short_f, 1'b0);
    rd(1'b0, 0, w);
    chk("x197_word0", w, 32'h06050403);
    check_data();

    // reset in the middle of a frame discards it and clears sticky flags
    for (int k = 0; k < 50; k++) begin
      for (int j = 0; j < 4; j++) din[j] = pix_t'(k + j);
      shift = 1'b1;
      tick();
    end
    rst = 1'b1; shift = 1'b0;
    tick();
    chk("midrst_banks", bvalid, 2'b00);
    chk("midrst_overrun", overrun, 1'b0);
    chk("midrst_short", short_f, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rxdone", rxdone, 1'b0);
    chk("midrst_dout", dout_w(), 32'h0);
    rst = 1'b0;
    model_clear();
    tick();
    send_frame(196, 11, 1'b0);
    chk("postrst_banks", bvalid, 2'b01);
    check_state();
    check_data();

    // random operations against the frame-level model
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 5))
        0:       rel(1'($urandom_range(0, 1)));
        1:       send_frame($urandom_range(1, 60), 0, 1'b1);
        2:       send_frame(197, 0, 1'b1);
        default: send_frame(196, 0, 1'b1);
      endcase
      check_state();
      check_data();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
